// File: rtl/sz_pred_feed.sv
// Operand feeder for the SZ predictor subtract stage: pairs each sample with its
// preceding-neighbour prediction and delays the sideband to line up with the result.
module sz_pred_feed #(
    parameter int SUB_LAT   = 8,
    parameter int BLOCK_LEN = 1024,
    parameter int IDX_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic [31:0]      sub_a,
    output logic [31:0]      sub_b,
    output logic             sub_valid,
    output logic             res_valid,
    output logic [31:0]      res_orig,
    output logic [31:0]      res_pred,
    output logic             res_first,
    output logic [IDX_W-1:0] res_idx
);

    // Handshake: no backpressure. in_valid marks a real sample on the cycle it is
    // high; every output valid marks a real sample on the cycle it is high, and
    // all data fields accompanying a low valid are zero.
    typedef struct packed {
        logic             valid;
        logic [31:0]      a;
        logic [31:0]      b;
        logic             first;
        logic [IDX_W-1:0] idx;
    } beat_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

    logic [31:0]      hist_q, hist_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    beat_t            s1_q, s1_d;
    beat_t            pipe_q [SUB_LAT];
    beat_t            pipe_d [SUB_LAT];

    always_comb begin
        hist_d = hist_q;
        cnt_d  = cnt_q;
        s1_d   = '0;
        if (in_valid) begin
            s1_d.valid = 1'b1;
            s1_d.a     = in_data;
            // Block start predicts 0.0 so no history leaks across blocks.
            s1_d.b     = (cnt_q == '0) ? 32'h0000_0000 : hist_q;
            s1_d.first = (cnt_q == '0);
            s1_d.idx   = cnt_q;
            hist_d     = in_data;
            cnt_d      = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        pipe_d[0] = s1_q;
        for (int k = 1; k < SUB_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            cnt_q  <= '0;
            s1_q   <= '0;
            for (int k = 0; k < SUB_LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
            s1_q   <= s1_d;
            for (int k = 0; k < SUB_LAT; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    assign sub_a     = s1_q.a;
    assign sub_b     = s1_q.b;
    assign sub_valid = s1_q.valid;

    assign res_valid = pipe_q[SUB_LAT-1].valid;
    assign res_orig  = pipe_q[SUB_LAT-1].a;
    assign res_pred  = pipe_q[SUB_LAT-1].b;
    assign res_first = pipe_q[SUB_LAT-1].first;
    assign res_idx   = pipe_q[SUB_LAT-1].idx;

endmodule

// File: tb/tb_sz_pred_feed.sv
// Bench for sz_pred_feed: three instances (long block, 4-sample block, 1-sample
// block) share one input stream and are checked against a cycle-indexed model.
module tb_sz_pred_feed;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic        first;
        logic [9:0]  idx;
    } rec_t;

    localparam int LAT  [3] = '{8, 3, 1};
    localparam int BLEN [3] = '{1024, 4, 1};
    localparam int LOGN = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;

    logic [31:0] d0_sub_a, d0_sub_b, d0_res_orig, d0_res_pred;
    logic        d0_sub_valid, d0_res_valid, d0_res_first;
    logic [9:0]  d0_res_idx;
    logic [31:0] d4_sub_a, d4_sub_b, d4_res_orig, d4_res_pred;
    logic        d4_sub_valid, d4_res_valid, d4_res_first;
    logic [1:0]  d4_res_idx;
    logic [31:0] d1_sub_a, d1_sub_b, d1_res_orig, d1_res_pred;
    logic        d1_sub_valid, d1_res_valid, d1_res_first;
    logic [0:0]  d1_res_idx;

    sz_pred_feed #(.SUB_LAT(8), .BLOCK_LEN(1024), .IDX_W(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .sub_a(d0_sub_a), .sub_b(d0_sub_b), .sub_valid(d0_sub_valid),
        .res_valid(d0_res_valid), .res_orig(d0_res_orig), .res_pred(d0_res_pred),
        .res_first(d0_res_first), .res_idx(d0_res_idx)
    );

    sz_pred_feed #(.SUB_LAT(3), .BLOCK_LEN(4), .IDX_W(2)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .sub_a(d4_sub_a), .sub_b(d4_sub_b), .sub_valid(d4_sub_valid),
        .res_valid(d4_res_valid), .res_orig(d4_res_orig), .res_pred(d4_res_pred),
        .res_first(d4_res_first), .res_idx(d4_res_idx)
    );

    sz_pred_feed #(.SUB_LAT(1), .BLOCK_LEN(1), .IDX_W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .sub_a(d1_sub_a), .sub_b(d1_sub_b), .sub_valid(d1_sub_valid),
        .res_valid(d1_res_valid), .res_orig(d1_res_orig), .res_pred(d1_res_pred),
        .res_first(d1_res_first), .res_idx(d1_res_idx)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- observed outputs ----------------
    logic [64:0] obs_s1  [3];
    rec_t        obs_res [3];
    assign obs_s1[0]  = {d0_sub_valid, d0_sub_a, d0_sub_b};
    assign obs_s1[1]  = {d4_sub_valid, d4_sub_a, d4_sub_b};
    assign obs_s1[2]  = {d1_sub_valid, d1_sub_a, d1_sub_b};
    assign obs_res[0] = {d0_res_valid, d0_res_orig, d0_res_pred, d0_res_first, d0_res_idx};
    assign obs_res[1] = {d4_res_valid, d4_res_orig, d4_res_pred, d4_res_first, 8'd0, d4_res_idx};
    assign obs_res[2] = {d1_res_valid, d1_res_orig, d1_res_pred, d1_res_first, 9'd0, d1_res_idx};

    // ---------------- model ----------------
    // log_s1[i][n] is what the operand stage of instance i must hold after edge n;
    // the result side is simply that log read LAT edges back.
    rec_t        log_s1 [3][LOGN];
    rec_t        exp_s1 [3];
    rec_t        exp_res [3];
    logic [31:0] m_hist [3];
    int          m_cnt [3];
    int          cyc = 0;
    bit          started = 0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < LOGN; n++) log_s1[i][n] = '0;
            m_hist[i] = '0;
            m_cnt[i]  = 0;
        end
    end

    always @(posedge clk) begin
        logic        s_rst, s_v;
        logic [31:0] s_d;
        s_rst = rst;
        s_v   = in_valid;
        s_d   = in_data;
        if (s_rst) started = 1;
        if (started && cyc < LOGN) begin
            for (int i = 0; i < 3; i++) begin
                if (s_rst) begin
                    m_hist[i]  = '0;
                    m_cnt[i]   = 0;
                    exp_s1[i]  = '0;
                    exp_res[i] = '0;
                    for (int k = 0; k <= LAT[i]; k++)
                        if (cyc - k >= 0) log_s1[i][cyc-k] = '0;
                end else begin
                    exp_s1[i] = '0;
                    if (s_v) begin
                        exp_s1[i].valid = 1'b1;
                        exp_s1[i].a     = s_d;
                        exp_s1[i].b     = (m_cnt[i] == 0) ? 32'h0 : m_hist[i];
                        exp_s1[i].first = (m_cnt[i] == 0);
                        exp_s1[i].idx   = 10'(m_cnt[i]);
                        m_hist[i] = s_d;
                        m_cnt[i]  = (m_cnt[i] + 1) % BLEN[i];
                    end
                    log_s1[i][cyc] = exp_s1[i];
                    exp_res[i] = (cyc >= LAT[i]) ? log_s1[i][cyc-LAT[i]] : '0;
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_s1[i] !== {exp_s1[i].valid, exp_s1[i].a, exp_s1[i].b}) begin
                    errors++;
                    $display("FAIL model_s1 inst%0d cyc %0d got %h want %h", i, cyc,
                             obs_s1[i], {exp_s1[i].valid, exp_s1[i].a, exp_s1[i].b});
                end
                checks++;
                if (obs_res[i] !== exp_res[i]) begin
                    errors++;
                    $display("FAIL model_res inst%0d cyc %0d got %h want %h", i, cyc,
                             obs_res[i], exp_res[i]);
                end
            end
        end
        if (started) cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = v ? d : 32'h0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 32'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_res(input logic v, input logic [31:0] orig, input logic [31:0] pred,
                             input logic first, input logic [9:0] idx);
        chk("res_valid", 32'(d0_res_valid), 32'(v));
        chk("res_orig",  d0_res_orig, orig);
        chk("res_pred",  d0_res_pred, pred);
        chk("res_first", 32'(d0_res_first), 32'(first));
        chk("res_idx",   32'(d0_res_idx), 32'(idx));
    endtask

    task automatic wait_res_valid();
        int k;
        k = 0;
        while (!d0_res_valid && k < 20) begin
            drive(1'b0, 32'h0);
            k++;
        end
        checks++;
        if (!d0_res_valid) begin
            errors++;
            $display("FAIL res_timeout got %0d want 1", d0_res_valid);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_res_valid", 32'(d0_res_valid), 32'h0);
        chk("reset_sub_valid", 32'(d0_sub_valid), 32'h0);
        chk("reset_sub_a", d0_sub_a, 32'h0);

        // Consecutive stream 1.0, 2.5, 3.0
        drive(1'b1, 32'h3F80_0000);
        chk("t1_a0", d0_sub_a, 32'h3F80_0000);
        chk("t1_b0", d0_sub_b, 32'h0);
        drive(1'b1, 32'h4020_0000);
        chk("t1_b1", d0_sub_b, 32'h3F80_0000);
        chk("t1_bl1_b1", d1_sub_b, 32'h0);
        chk("t1_bl1_orig", d1_res_orig, 32'h3F80_0000);
        drive(1'b1, 32'h4040_0000);
        chk("t1_b2", d0_sub_b, 32'h4020_0000);
        chk("t1_bl1_pred", d1_res_pred, 32'h0);
        chk("t1_bl1_first", 32'(d1_res_first), 32'h1);
        wait_res_valid();
        check_res(1'b1, 32'h3F80_0000, 32'h0, 1'b1, 10'd0);
        drive(1'b0, 32'h0);
        check_res(1'b1, 32'h4020_0000, 32'h3F80_0000, 1'b0, 10'd1);
        drive(1'b0, 32'h0);
        check_res(1'b1, 32'h4040_0000, 32'h4020_0000, 1'b0, 10'd2);

        // Gap of three idle cycles inside the stream
        pulse_reset();
        drive(1'b1, 32'h3F80_0000);
        drive(1'b1, 32'h4020_0000);
        for (int k = 0; k < 3; k++) drive(1'b0, 32'h0);
        drive(1'b1, 32'h4040_0000);
        chk("t2_b_after_gap", d0_sub_b, 32'h4020_0000);
        wait_res_valid();
        check_res(1'b1, 32'h3F80_0000, 32'h0, 1'b1, 10'd0);
        drive(1'b0, 32'h0);
        check_res(1'b1, 32'h4020_0000, 32'h3F80_0000, 1'b0, 10'd1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0);
            check_res(1'b0, 32'h0, 32'h0, 1'b0, 10'd0);
        end
        drive(1'b0, 32'h0);
        check_res(1'b1, 32'h4040_0000, 32'h4020_0000, 1'b0, 10'd2);

        // Block wrap on the 4-sample instance, wrap sample arrives after a gap
        pulse_reset();
        drive(1'b1, 32'h3F80_0000);
        drive(1'b1, 32'h4000_0000);
        drive(1'b1, 32'h4040_0000);
        drive(1'b1, 32'h4080_0000);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        drive(1'b1, 32'h40A0_0000);
        chk("t3_a_wrap", d4_sub_a, 32'h40A0_0000);
        chk("t3_b_wrap", d4_sub_b, 32'h0);
        drive(1'b1, 32'h40C0_0000);
        chk("t3_b_next", d4_sub_b, 32'h40A0_0000);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        chk("t3_res_orig", d4_res_orig, 32'h40A0_0000);
        chk("t3_res_first", 32'(d4_res_first), 32'h1);
        chk("t3_res_idx", 32'(d4_res_idx), 32'h0);
        drive(1'b0, 32'h0);
        chk("t3_res_pred6", d4_res_pred, 32'h40A0_0000);
        chk("t3_res_idx6", 32'(d4_res_idx), 32'h1);
        chk("t3_res_first6", 32'(d4_res_first), 32'h0);

        // Reset while samples are in flight
        pulse_reset();
        for (int k = 0; k < 4; k++) drive(1'b1, 32'h3F80_0000 + 32'(k) * 32'h0010_0000);
        pulse_reset();
        chk("t4_hold_r0", 32'(d0_res_valid), 32'h0);
        drive(1'b1, 32'h4100_0000);
        chk("t4_b_post", d0_sub_b, 32'h0);
        chk("t4_hold_r1", 32'(d0_res_valid), 32'h0);
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 32'h0);
            chk("t4_hold", 32'(d0_res_valid), 32'h0);
        end
        drive(1'b0, 32'h0);
        check_res(1'b1, 32'h4100_0000, 32'h0, 1'b1, 10'd0);

        // Special values pass bit-exact
        pulse_reset();
        drive(1'b1, 32'h7FC0_0000);
        drive(1'b1, 32'h8000_0000);
        chk("t5_a_negz", d0_sub_a, 32'h8000_0000);
        chk("t5_b_nan", d0_sub_b, 32'h7FC0_0000);
        wait_res_valid();
        check_res(1'b1, 32'h7FC0_0000, 32'h0, 1'b1, 10'd0);
        drive(1'b0, 32'h0);
        check_res(1'b1, 32'h8000_0000, 32'h7FC0_0000, 1'b0, 10'd1);

        // One-sample blocks
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h4040_0000 + 32'(k));
            chk("t6_bl1_b", d1_sub_b, 32'h0);
            if (k > 0) begin
                chk("t6_bl1_first", 32'(d1_res_first), 32'h1);
                chk("t6_bl1_idx", 32'(d1_res_idx), 32'h0);
            end
        end
        for (int k = 0; k < 12; k++) drive(1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
